// File: rtl/pipeline_output_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pipe_arb_pkg                                                 |
// | Description : Shared lane identifiers, arbiter state encoding and          |
// |               FIFO-depth-derived width helper for pipeline_output_arbiter. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_arb_pkg;

   // Lane identifiers as driven on out_lane.
   localparam logic LANE_1 = 1'b0;
   localparam logic LANE_2 = 1'b1;

   // Arbiter state doubles as the current grant.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_1 = 2'd1,
      ST_SERVE_2 = 2'd2
   } arb_state_t;

   // Pointer width for a FIFO of the given (power-of-two) depth.
   // Occupancy counters are one bit wider so that "full" is representable.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_output_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : pipeline_output_arbiter_if                                   |
// | Description : Bundles the two producer lanes, the shared sink port and the |
// |               status outputs of pipeline_output_arbiter.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   in_valid_x / in_data_x / in_flush_x : lane x beat, data, flush marker    |
// |   out_ready                           : sink accepts the presented beat    |
// |   out_valid / out_data / out_lane / out_flush : presented beat             |
// |   stall_1 / stall_2                   : backpressure to each producer      |
// |   overflow_err                        : sticky dropped-beat flag           |
// | Modports                                                                   |
// |   slave  : the arbiter itself                                              |
// |   master : the environment (producers + sink)                              |
// +----------------------------------------------------------------------------+
interface pipeline_output_arbiter_if #(
   parameter int DATA_W = 32
) ();

   logic              in_valid_1;
   logic [DATA_W-1:0] in_data_1;
   logic              in_flush_1;
   logic              in_valid_2;
   logic [DATA_W-1:0] in_data_2;
   logic              in_flush_2;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_lane;
   logic              out_flush;
   logic              stall_1;
   logic              stall_2;
   logic              overflow_err;

   modport slave (
      input  in_valid_1, in_data_1, in_flush_1,
      input  in_valid_2, in_data_2, in_flush_2,
      input  out_ready,
      output out_valid, out_data, out_lane, out_flush,
      output stall_1, stall_2, overflow_err
   );

   modport master (
      output in_valid_1, in_data_1, in_flush_1,
      output in_valid_2, in_data_2, in_flush_2,
      output out_ready,
      input  out_valid, out_data, out_lane, out_flush,
      input  stall_1, stall_2, overflow_err
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_output_arbiter_lane_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_fifo                                                    |
// | Description : Single-clock circular FIFO holding one lane's beats.         |
// |               Head entry is read combinationally from the storage array.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset : clock, synchronous active-high reset                        |
// |   i_push     : write i_wdata (caller guarantees not full)                  |
// |   i_pop      : discard head entry (caller guarantees not empty)            |
// |   o_rdata    : head entry                                                  |
// |   o_count    : occupancy, 0..DEPTH                                         |
// |   o_full     : o_count == DEPTH                                            |
// |   o_empty    : o_count == 0                                                |
// +----------------------------------------------------------------------------+
module lane_fifo
   import pipe_arb_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  wire                                 clk,
   input  wire                                 reset,
   input  wire                                 i_push,
   input  wire  [WIDTH-1:0]                    i_wdata,
   input  wire                                 i_pop,
   output logic [WIDTH-1:0]                    o_rdata,
   output logic [ptr_width(DEPTH):0]           o_count,
   output logic                                o_full,
   output logic                                o_empty
);

   localparam int c_ptr_w = ptr_width(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full_lvl = c_cnt_w'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;

   // Storage needs no reset: occupancy tracking decides what is valid.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == c_full_lvl);
   assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipeline_output_arbiter                                      |
// | Description : Merges two stallable pipeline result lanes onto one sink.    |
// |               Each lane is buffered in a lane_fifo; the sink is granted    |
// |               round-robin and stall_x keeps producers from overflowing.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk   : rising-edge clock                                                |
// |   reset : synchronous active-high reset                                    |
// |   bus   : pipeline_output_arbiter_if.slave (lanes, sink, status)           |
// +----------------------------------------------------------------------------+
module pipeline_output_arbiter
   import pipe_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  wire                      clk,
   input  wire                      reset,
   pipeline_output_arbiter_if.slave bus
);

   localparam int c_cnt_w = ptr_width(DEPTH) + 1;
   localparam int c_ent_w = DATA_W + 1;
   localparam logic [c_cnt_w-1:0] c_stall_lvl = c_cnt_w'(DEPTH - 1);
   localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic               r_last_grant;
   logic               r_out_valid;
   logic               r_out_lane;
   logic               r_overflow;

   logic [c_ent_w-1:0] w_head_1;
   logic [c_ent_w-1:0] w_head_2;
   logic [c_ent_w-1:0] w_head_sel;
   logic [c_cnt_w-1:0] w_count_1;
   logic [c_cnt_w-1:0] w_count_2;
   logic               w_full_1;
   logic               w_full_2;
   logic               w_empty_1;
   logic               w_empty_2;
   logic               w_push_1;
   logic               w_push_2;
   logic               w_pop_1;
   logic               w_pop_2;
   logic               w_ne_1;
   logic               w_ne_2;

   // A beat arriving at a full FIFO is dropped rather than written.
   assign w_push_1 = bus.in_valid_1 & ~w_full_1;
   assign w_push_2 = bus.in_valid_2 & ~w_full_2;
   assign w_pop_1  = (r_state == ST_SERVE_1) & bus.out_ready;
   assign w_pop_2  = (r_state == ST_SERVE_2) & bus.out_ready;

   // Occupancy after this edge. Granting on it lets a beat pushed at edge t
   // be presented right after that edge while still reading it from storage.
   assign w_ne_1 = w_push_1 | (~w_empty_1 & ~(w_pop_1 & (w_count_1 == c_one)));
   assign w_ne_2 = w_push_2 | (~w_empty_2 & ~(w_pop_2 & (w_count_2 == c_one)));

   lane_fifo #(
      .WIDTH (c_ent_w),
      .DEPTH (DEPTH)
   ) u_fifo_1 (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push_1),
      .i_wdata ({bus.in_flush_1, bus.in_data_1}),
      .i_pop   (w_pop_1),
      .o_rdata (w_head_1),
      .o_count (w_count_1),
      .o_full  (w_full_1),
      .o_empty (w_empty_1)
   );

   lane_fifo #(
      .WIDTH (c_ent_w),
      .DEPTH (DEPTH)
   ) u_fifo_2 (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push_2),
      .i_wdata ({bus.in_flush_2, bus.in_data_2}),
      .i_pop   (w_pop_2),
      .o_rdata (w_head_2),
      .o_count (w_count_2),
      .o_full  (w_full_2),
      .o_empty (w_empty_2)
   );

   // Grant selection. After an accept the other lane is preferred, which
   // yields strict alternation while both lanes are backlogged.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_ne_1 && w_ne_2) begin
               w_state_nxt = (r_last_grant == LANE_2) ? ST_SERVE_1 : ST_SERVE_2;
            end else if (w_ne_1) begin
               w_state_nxt = ST_SERVE_1;
            end else if (w_ne_2) begin
               w_state_nxt = ST_SERVE_2;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SERVE_1: begin
            if (bus.out_ready) begin
               if (w_ne_2)      w_state_nxt = ST_SERVE_2;
               else if (w_ne_1) w_state_nxt = ST_SERVE_1;
               else             w_state_nxt = ST_IDLE;
            end
         end
         ST_SERVE_2: begin
            if (bus.out_ready) begin
               if (w_ne_1)      w_state_nxt = ST_SERVE_1;
               else if (w_ne_2) w_state_nxt = ST_SERVE_2;
               else             w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= LANE_2;
         r_out_valid  <= 1'b0;
         r_out_lane   <= LANE_1;
         r_overflow   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt != ST_IDLE);
         r_out_lane  <= (w_state_nxt == ST_SERVE_2) ? LANE_2 : LANE_1;
         if (w_pop_1) begin
            r_last_grant <= LANE_1;
         end else if (w_pop_2) begin
            r_last_grant <= LANE_2;
         end
         r_overflow <= r_overflow | (bus.in_valid_1 & w_full_1)
                                  | (bus.in_valid_2 & w_full_2);
      end
   end

   // Head of the granted FIFO; zero while idle. The head only changes on a
   // pop, so the presented beat is stable while the sink stalls.
   always_comb begin
      w_head_sel = '0;
      if (r_state == ST_SERVE_1) begin
         w_head_sel = w_head_1;
      end else if (r_state == ST_SERVE_2) begin
         w_head_sel = w_head_2;
      end
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.out_lane     = r_out_lane;
   assign bus.out_data     = w_head_sel[DATA_W-1:0];
   assign bus.out_flush    = w_head_sel[DATA_W];
   // One slot of headroom covers the beat already in flight from the producer.
   assign bus.stall_1      = (w_count_1 >= c_stall_lvl);
   assign bus.stall_2      = (w_count_2 >= c_stall_lvl);
   assign bus.overflow_err = r_overflow;

endmodule
`default_nettype wire
